mcy_mutsel_ctrl: RTL and testbench
==================================

Name: mcy_mutsel_ctrl

Overview:
Multi-channel mutation-selection controller for MCY mutation-coverage runs on the cv32e40p core. It generalises the single static 8-bit mutation index into NUM_CH independently configured channels, each of parametrised width. Each channel drives its index into a mutated instance only during a programmable activation window: always, delayed, windowed, or trigger-started. Per-channel saturating counters record how often the mutated site was exercised while active. It sits between the testbench configuration path (DPI-driven) and the mutsel inputs of one or more mutated modules.

Parameters:
MUTSEL_W, 8, width of one mutation index; index 0 means "no mutation"
NUM_CH, 2, number of independent mutation channels (>=1)
CNT_W, 32, width of delay, length and hit counters
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel-select width (derived, not overridden)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
cfg_valid_i  in  1  configuration write request
cfg_ready_o  out  1  selected channel accepts configuration
cfg_ch_i  in  CH_W  target channel of the configuration write
cfg_idx_i  in  MUTSEL_W  mutation index for the channel
cfg_mode_i  in  2  0 ALWAYS, 1 DELAYED, 2 WINDOW, 3 TRIGGERED
cfg_delay_i  in  CNT_W  cycles from start to activation
cfg_len_i  in  CNT_W  active cycles (WINDOW/TRIGGERED only)
arm_i  in  1  start all configured channels
disarm_i  in  1  force all channels to IDLE
trigger_i  in  1  start event for TRIGGERED channels
cov_hit_i  in  NUM_CH  per-channel "mutated site exercised" strobe from the mutated design
mutsel_o  out  NUM_CH*MUTSEL_W  per-channel index; channel k occupies bits [k*MUTSEL_W +: MUTSEL_W]
active_o  out  NUM_CH  channel currently in ACTIVE
done_o  out  NUM_CH  channel finished its window
hit_cnt_o  out  NUM_CH*CNT_W  per-channel saturating hit count

Behaviour:
- Reset: all channels IDLE, unconfigured; mutsel_o=0, active_o=0, done_o=0, hit_cnt_o=0, cfg_ready_o=1.
- Per-channel states: IDLE, WAIT_TRIG, DELAY, ACTIVE, DONE.
- cfg_ready_o = 1 when channel cfg_ch_i is IDLE or DONE (combinational). A write completes on cfg_valid_i & cfg_ready_o. It latches idx/mode/delay/len, sets the configured flag, clears that channel's hit count, and returns the channel to IDLE. Writes to a busy channel are ignored and do not change state.
- cfg_ch_i >= NUM_CH: cfg_ready_o=1 and the write is dropped.
- Start of a channel: arm_i at cycle t, with the channel configured and in IDLE or DONE.
  - TRIGGERED mode goes to WAIT_TRIG.
  - All other modes start immediately. If delay==0 the channel enters ACTIVE at t+1; otherwise it enters DELAY, counts down, and is ACTIVE at t+1+delay.
- WAIT_TRIG: trigger_i sampled high at cycle t' starts the delay sequence with the same timing as above, relative to t'. A trigger in the arm cycle itself is ignored.
- ACTIVE:
  - ALWAYS and DELAYED stay ACTIVE until disarm.
  - WINDOW and TRIGGERED stay ACTIVE for exactly len cycles, then go to DONE.
  - len==0 goes directly to DONE without ever being active. done_o rises in the cycle the channel would otherwise have gone active.
- mutsel_o slice = latched idx while ACTIVE, else 0. active_o = (state==ACTIVE). done_o = (state==DONE).
- Hit counter: increments when ACTIVE & cov_hit_i[k]; saturates at all-ones; holds through DONE and disarm; cleared only by reset or a cfg write to that channel.
- disarm_i: all channels go to IDLE next cycle; configuration is retained. It wins over arm_i and trigger_i in the same cycle. A same-cycle cfg write is still accepted.
- arm_i while a channel is in DELAY, WAIT_TRIG or ACTIVE: ignored for that channel (no restart).
- Channels are fully independent apart from the shared arm_i, disarm_i and trigger_i.
- Reset mid-operation: immediate return to the reset values listed above; configuration is lost.
- All outputs are registered except cfg_ready_o.

Test Plan:
- Reset, then cfg ch0 idx=0x2A mode=ALWAYS, arm at cycle 10 -> mutsel_o[7:0]=0x2A and active_o[0]=1 from cycle 11; disarm at cycle 20 -> mutsel_o[7:0]=0 from cycle 21.
- ch1 idx=0x05 mode=WINDOW delay=3 len=4, arm at cycle 0 -> active_o[1]=1 on cycles 4..7, done_o[1]=1 from cycle 8; cov_hit_i[1] held high throughout -> hit_cnt_o ch1=4.
- ch0 mode=TRIGGERED delay=0 len=2; trigger in the arm cycle, then trigger at cycle 5 -> first trigger ignored, active on cycles 6..7, then DONE.
- cfg write to ch1 while it is ACTIVE -> cfg_ready_o=0, config and hit count unchanged; write after DONE -> accepted, hit count 0.
- WINDOW len=0 -> active_o never asserts, done_o=1 at t+1+delay. With CNT_W=4 and 20 active hit cycles -> hit_cnt saturates at 15.
- arm and disarm in the same cycle -> all channels remain IDLE; rst_ni asserted while ACTIVE -> mutsel_o=0 immediately (asynchronously).

Source files
------------

// File: rtl/mcy_mutsel_ctrl.sv
// Multi-channel mutation-selection controller: each channel drives its mutation index
// only inside a programmable activation window and counts coverage hits while active.
module mcy_mutsel_ctrl #(
  parameter int MUTSEL_W = 8,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [CH_W-1:0]              cfg_ch_i,
  input  logic [MUTSEL_W-1:0]          cfg_idx_i,
  input  logic [1:0]                   cfg_mode_i,
  input  logic [CNT_W-1:0]             cfg_delay_i,
  input  logic [CNT_W-1:0]             cfg_len_i,
  input  logic                         arm_i,
  input  logic                         disarm_i,
  input  logic                         trigger_i,
  input  logic [NUM_CH-1:0]            cov_hit_i,
  output logic [NUM_CH*MUTSEL_W-1:0]   mutsel_o,
  output logic [NUM_CH-1:0]            active_o,
  output logic [NUM_CH-1:0]            done_o,
  output logic [NUM_CH*CNT_W-1:0]      hit_cnt_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_DELAY  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] MODE_TRIG = 2'd3;

  logic [NUM_CH-1:0]       ch_ready;
  logic [(1<<CH_W)-1:0]    ready_vec;

  // Unimplemented channel numbers read as ready so a stray write never stalls the config path.
  for (genvar gi = 0; gi < (1 << CH_W); gi++) begin : g_ready
    if (gi < NUM_CH) begin : g_real
      assign ready_vec[gi] = ch_ready[gi];
    end else begin : g_pad
      assign ready_vec[gi] = 1'b1;
    end
  end

  assign cfg_ready_o = ready_vec[cfg_ch_i];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [2:0]          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [MUTSEL_W-1:0] idx_reg;
    logic [1:0]          mode_reg;
    logic [CNT_W-1:0]    delay_reg, len_reg, hit_reg;
    logic                configured_reg;
    logic [MUTSEL_W-1:0] mutsel_reg;
    logic                active_reg, done_reg;
    logic                cfg_we, launch, expire, windowed;

    assign ch_ready[gi] = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign cfg_we       = cfg_valid_i && (cfg_ch_i == CH_W'(gi)) && ch_ready[gi];
    assign windowed     = mode_reg[1];

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      launch     = 1'b0;
      expire     = 1'b0;
      if (disarm_i || cfg_we) begin
        state_next = ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (arm_i && configured_reg) begin
              if (mode_reg == MODE_TRIG) state_next = ST_WAIT;
              else                       launch     = 1'b1;
            end
          end
          ST_WAIT:  launch = trigger_i;
          ST_DELAY: begin
            if (cnt_reg == '0) expire = 1'b1;
            else               cnt_next = cnt_reg - CNT_W'(1);
          end
          ST_ACTIVE: begin
            if (windowed) begin
              if (cnt_reg == '0) state_next = ST_DONE;
              else               cnt_next   = cnt_reg - CNT_W'(1);
            end
          end
          default: state_next = ST_IDLE;
        endcase
        if (launch) begin
          if (delay_reg == '0) begin
            expire = 1'b1;
          end else begin
            state_next = ST_DELAY;
            cnt_next   = delay_reg - CNT_W'(1);
          end
        end
        // A zero-length window skips ACTIVE and reports completion at the activation point.
        if (expire) begin
          if (windowed && len_reg == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ACTIVE;
            cnt_next   = len_reg - CNT_W'(1);
          end
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg      <= ST_IDLE;
        cnt_reg        <= '0;
        idx_reg        <= '0;
        mode_reg       <= '0;
        delay_reg      <= '0;
        len_reg        <= '0;
        hit_reg        <= '0;
        configured_reg <= 1'b0;
        mutsel_reg     <= '0;
        active_reg     <= 1'b0;
        done_reg       <= 1'b0;
      end else begin
        state_reg  <= state_next;
        cnt_reg    <= cnt_next;
        mutsel_reg <= (state_next == ST_ACTIVE) ? idx_reg : '0;
        active_reg <= (state_next == ST_ACTIVE);
        done_reg   <= (state_next == ST_DONE);
        if (cfg_we) begin
          idx_reg        <= cfg_idx_i;
          mode_reg       <= cfg_mode_i;
          delay_reg      <= cfg_delay_i;
          len_reg        <= cfg_len_i;
          configured_reg <= 1'b1;
          hit_reg        <= '0;
        end else if (state_reg == ST_ACTIVE && cov_hit_i[gi] && hit_reg != '1) begin
          hit_reg <= hit_reg + CNT_W'(1);
        end
      end
    end

    assign mutsel_o[gi*MUTSEL_W +: MUTSEL_W] = mutsel_reg;
    assign active_o[gi]                      = active_reg;
    assign done_o[gi]                        = done_reg;
    assign hit_cnt_o[gi*CNT_W +: CNT_W]      = hit_reg;
  end

endmodule

// File: tb/tb_mcy_mutsel_ctrl.sv
// Directed bench for mcy_mutsel_ctrl: default instance plus a narrow-counter,
// three-channel instance for saturation and out-of-range channel writes.
module tb_mcy_mutsel_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cfg_valid, cfg_ready, arm, disarm, trigger;
  logic [0:0]  cfg_ch;
  logic [7:0]  cfg_idx;
  logic [1:0]  cfg_mode, cov_hit, active, done;
  logic [31:0] cfg_delay, cfg_len;
  logic [15:0] mutsel;
  logic [63:0] hit_cnt;

  logic        s_cfg_valid, s_cfg_ready, s_arm, s_disarm, s_trigger;
  logic [1:0]  s_cfg_ch, s_cfg_mode;
  logic [7:0]  s_cfg_idx;
  logic [3:0]  s_cfg_delay, s_cfg_len;
  logic [2:0]  s_cov_hit, s_active, s_done;
  logic [23:0] s_mutsel;
  logic [11:0] s_hit_cnt;

  int nvec = 0;
  int nerr = 0;

  mcy_mutsel_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_idx_i(cfg_idx), .cfg_mode_i(cfg_mode), .cfg_delay_i(cfg_delay),
    .cfg_len_i(cfg_len), .arm_i(arm), .disarm_i(disarm), .trigger_i(trigger),
    .cov_hit_i(cov_hit), .mutsel_o(mutsel), .active_o(active), .done_o(done),
    .hit_cnt_o(hit_cnt)
  );

  mcy_mutsel_ctrl #(.MUTSEL_W(8), .NUM_CH(3), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(s_cfg_valid), .cfg_ready_o(s_cfg_ready),
    .cfg_ch_i(s_cfg_ch), .cfg_idx_i(s_cfg_idx), .cfg_mode_i(s_cfg_mode), .cfg_delay_i(s_cfg_delay),
    .cfg_len_i(s_cfg_len), .arm_i(s_arm), .disarm_i(s_disarm), .trigger_i(s_trigger),
    .cov_hit_i(s_cov_hit), .mutsel_o(s_mutsel), .active_o(s_active), .done_o(s_done),
    .hit_cnt_o(s_hit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic ch, input logic [7:0] idx, input logic [1:0] mode,
                           input logic [31:0] dly, input logic [31:0] len);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_idx = idx; cfg_mode = mode;
    cfg_delay = dly;  cfg_len = len;
    tick();
    cfg_valid = 1'b0;
    $display("cfg ch%0d idx=%02h mode=%0d delay=%0d len=%0d", ch, idx, mode, dly, len);
  endtask

  task automatic disarm_pulse();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 0; cfg_ch = 0; cfg_idx = 0; cfg_mode = 0; cfg_delay = 0; cfg_len = 0;
    arm = 0; disarm = 0; trigger = 0; cov_hit = 0;
    s_cfg_valid = 0; s_cfg_ch = 0; s_cfg_idx = 0; s_cfg_mode = 0; s_cfg_delay = 0; s_cfg_len = 0;
    s_arm = 0; s_disarm = 0; s_trigger = 0; s_cov_hit = 0;
    tick(); tick();
    nvec++; if (mutsel !== 16'h0) begin nerr++; $display("FAIL reset_mutsel got %h want 0000", mutsel); end
    nvec++; if (active !== 2'b00) begin nerr++; $display("FAIL reset_active got %b want 00", active); end
    nvec++; if (done !== 2'b00) begin nerr++; $display("FAIL reset_done got %b want 00", done); end
    nvec++; if (hit_cnt !== 64'h0) begin nerr++; $display("FAIL reset_hit got %h want 0", hit_cnt); end
    nvec++; if (cfg_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_always();
    cfg_write(1'b0, 8'h2A, 2'd0, 32'd0, 32'd0);
    repeat (8) tick();
    nvec++; if (active[0] !== 1'b0) begin nerr++; $display("FAIL always_idle got %b want 0", active[0]); end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int c = 0; c < 9; c++) begin
      nvec++; if (mutsel[7:0] !== 8'h2A || active[0] !== 1'b1)
        begin nerr++; $display("FAIL always_on cyc%0d got mutsel=%h act=%b want 2a/1", c, mutsel[7:0], active[0]); end
      tick();
    end
    nvec++; if (mutsel[15:8] !== 8'h00) begin nerr++; $display("FAIL always_ch1_quiet got %h want 00", mutsel[15:8]); end
    disarm_pulse();
    nvec++; if (mutsel[7:0] !== 8'h00 || active[0] !== 1'b0)
      begin nerr++; $display("FAIL always_disarm got mutsel=%h act=%b want 00/0", mutsel[7:0], active[0]); end
    $display("always mode checked");
  endtask

  task automatic test_window();
    logic exp_act;
    cov_hit = 2'b10;
    cfg_write(1'b1, 8'h05, 2'd2, 32'd3, 32'd4);
    arm = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) arm = 1'b0;
      exp_act = (c >= 4 && c <= 7);
      nvec++; if (active[1] !== exp_act || done[1] !== (c >= 8) || mutsel[15:8] !== (exp_act ? 8'h05 : 8'h00))
        begin nerr++; $display("FAIL window cyc%0d got act=%b done=%b idx=%h want act=%b done=%b", c, active[1], done[1], mutsel[15:8], exp_act, c >= 8); end
    end
    cov_hit = 2'b00;
    nvec++; if (hit_cnt[63:32] !== 32'd4) begin nerr++; $display("FAIL window_hits got %0d want 4", hit_cnt[63:32]); end
    disarm_pulse();
    nvec++; if (hit_cnt[63:32] !== 32'd4 || done[1] !== 1'b0)
      begin nerr++; $display("FAIL window_disarm got hits=%0d done=%b want 4/0", hit_cnt[63:32], done[1]); end
    $display("window mode checked");
  endtask

  task automatic test_triggered();
    logic exp_act;
    cfg_write(1'b0, 8'h3C, 2'd3, 32'd0, 32'd2);
    arm = 1'b1; trigger = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin arm = 1'b0; trigger = 1'b0; end
      if (c == 5) trigger = 1'b1;
      if (c == 6) trigger = 1'b0;
      exp_act = (c == 6 || c == 7);
      nvec++; if (active[0] !== exp_act || done[0] !== (c >= 8) || mutsel[7:0] !== (exp_act ? 8'h3C : 8'h00))
        begin nerr++; $display("FAIL trig cyc%0d got act=%b done=%b idx=%h want act=%b done=%b", c, active[0], done[0], mutsel[7:0], exp_act, c >= 8); end
    end
    disarm_pulse();
    $display("triggered mode checked");
  endtask

  task automatic test_busy_cfg();
    logic exp_act;
    cfg_write(1'b1, 8'h11, 2'd2, 32'd0, 32'd5);
    cov_hit = 2'b10;
    arm = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) arm = 1'b0;
      if (c == 2) begin
        cfg_ch = 1'b0;
        #1;
        nvec++; if (cfg_ready !== 1'b0) begin nerr++; $display("FAIL busy_ready_ch0 got %b want 0", cfg_ready); end
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_idx = 8'h77; cfg_mode = 2'd0; cfg_delay = 0; cfg_len = 1;
        #1;
        nvec++; if (cfg_ready !== 1'b0) begin nerr++; $display("FAIL busy_ready_ch1 got %b want 0", cfg_ready); end
      end
      if (c == 3) cfg_valid = 1'b0;
      exp_act = (c <= 5);
      nvec++; if (active[1] !== exp_act || done[1] !== (c == 6) || mutsel[15:8] !== (exp_act ? 8'h11 : 8'h00))
        begin nerr++; $display("FAIL busy cyc%0d got act=%b done=%b idx=%h want act=%b", c, active[1], done[1], mutsel[15:8], exp_act); end
    end
    nvec++; if (hit_cnt[63:32] !== 32'd5) begin nerr++; $display("FAIL busy_hits got %0d want 5", hit_cnt[63:32]); end
    cov_hit = 2'b00;
    tick(); tick();
    nvec++; if (hit_cnt[63:32] !== 32'd5 || done[1] !== 1'b1)
      begin nerr++; $display("FAIL done_hold got hits=%0d done=%b want 5/1", hit_cnt[63:32], done[1]); end
    cfg_ch = 1'b1;
    #1;
    nvec++; if (cfg_ready !== 1'b1) begin nerr++; $display("FAIL done_ready got %b want 1", cfg_ready); end
    cfg_write(1'b1, 8'h33, 2'd0, 32'd0, 32'd0);
    nvec++; if (hit_cnt[63:32] !== 32'd0 || done[1] !== 1'b0)
      begin nerr++; $display("FAIL recfg got hits=%0d done=%b want 0/0", hit_cnt[63:32], done[1]); end
    disarm_pulse();
    $display("busy config checked");
  endtask

  task automatic test_len_zero();
    cfg_write(1'b1, 8'h09, 2'd2, 32'd2, 32'd0);
    arm = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) arm = 1'b0;
      nvec++; if (active[1] !== 1'b0 || done[1] !== (c >= 3) || mutsel[15:8] !== 8'h00)
        begin nerr++; $display("FAIL len0 cyc%0d got act=%b done=%b idx=%h want 0/%b/00", c, active[1], done[1], mutsel[15:8], c >= 3); end
    end
    disarm_pulse();
    $display("zero-length window checked");
  endtask

  task automatic test_arm_disarm();
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0; trigger = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      nvec++; if (active !== 2'b00 || done !== 2'b00 || mutsel !== 16'h0)
        begin nerr++; $display("FAIL arm_disarm cyc%0d got act=%b done=%b idx=%h want idle", c, active, done, mutsel); end
      tick();
      if (c == 1) trigger = 1'b0;
    end
    $display("arm+disarm collision checked");
  endtask

  task automatic test_saturate();
    s_cfg_valid = 1'b1; s_cfg_ch = 2'd0; s_cfg_idx = 8'h03; s_cfg_mode = 2'd0;
    tick();
    s_cfg_valid = 1'b0;
    s_cov_hit = 3'b001;
    s_arm = 1'b1;
    tick();
    s_arm = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 11) begin
        nvec++; if (s_hit_cnt[3:0] !== 4'd10) begin nerr++; $display("FAIL sat_mid got %0d want 10", s_hit_cnt[3:0]); end
      end
      if (c == 5) begin
        s_cfg_ch = 2'd3;
        #1;
        nvec++; if (s_cfg_ready !== 1'b1) begin nerr++; $display("FAIL oor_ready got %b want 1", s_cfg_ready); end
        s_cfg_ch = 2'd0;
        #1;
        nvec++; if (s_cfg_ready !== 1'b0) begin nerr++; $display("FAIL sat_busy_ready got %b want 0", s_cfg_ready); end
        s_cfg_ch = 2'd3; s_cfg_valid = 1'b1; s_cfg_idx = 8'hEE;
      end
      if (c == 6) begin
        s_cfg_valid = 1'b0;
        nvec++; if (s_active !== 3'b001 || s_mutsel !== 24'h000003)
          begin nerr++; $display("FAIL oor_write got act=%b idx=%h want 001/000003", s_active, s_mutsel); end
      end
      tick();
    end
    nvec++; if (s_hit_cnt !== 12'h00F) begin nerr++; $display("FAIL sat_full got %h want 00f", s_hit_cnt); end
    s_cov_hit = 3'b000;
    s_disarm = 1'b1;
    tick();
    s_disarm = 1'b0;
    $display("saturation checked");
  endtask

  task automatic test_reset_async();
    cfg_write(1'b0, 8'h2A, 2'd0, 32'd0, 32'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    nvec++; if (active[0] !== 1'b1) begin nerr++; $display("FAIL pre_rst got %b want 1", active[0]); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (mutsel !== 16'h0 || active !== 2'b00)
      begin nerr++; $display("FAIL async_rst got idx=%h act=%b want 0000/00", mutsel, active); end
    #2 rst_n = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    nvec++; if (active[0] !== 1'b0 || mutsel[7:0] !== 8'h00)
      begin nerr++; $display("FAIL cfg_lost got act=%b idx=%h want 0/00", active[0], mutsel[7:0]); end
    $display("asynchronous reset checked");
  endtask

  initial begin
    test_reset();
    test_always();
    test_window();
    test_triggered();
    test_busy_cfg();
    test_len_zero();
    test_arm_disarm();
    test_saturate();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
